// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity bit, STOP_BITS stop bits, with an internal bit-period counter.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 dout,
   output logic                 tx_status,
   output logic                 tx_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
         $error("uart_tx_frame: CLKS_PER_BIT must be in 2..65535");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_frame: DATA_BITS must be in 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_frame: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_frame: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 dout_q, dout_d;
   logic                 status_q, status_d;

   logic                 bit_end;
   logic                 last_stop;
   logic                 accept;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      dout_d    = 1'b1;
      status_d  = 1'b1;

      bit_end   = (cnt_q == CNT_LAST);
      last_stop = (state_q == ST_STOP) && bit_end && (bit_q == STOP_LAST);
      tx_ready  = (state_q == ST_IDLE) || last_stop;
      tx_done   = last_stop;
      accept    = tx_valid && tx_ready;

      if (state_q != ST_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY == 0) ? ST_STOP : ST_PARITY;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  state_d = ST_IDLE;
                  bit_d   = '0;
               end else begin
                  bit_d   = bit_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Acceptance overrides the stop-bit exit so back-to-back frames have no idle gap.
      if (accept) begin
         state_d = ST_START;
         cnt_d   = '0;
         bit_d   = '0;
         shift_d = tx_data;
         par_d   = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
      end

      // The line level is registered, so it is derived from the state being entered.
      case (state_d)
         ST_START:  dout_d = 1'b0;
         ST_DATA:   dout_d = shift_d[0];
         ST_PARITY: dout_d = par_q;
         default:   dout_d = 1'b1;
      endcase

      status_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         dout_q   <= 1'b1;
         status_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         dout_q   <= dout_d;
         status_q <= status_d;
      end
   end

   assign dout      = dout_q;
   assign tx_status = status_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover no/even/odd parity
// at 4 clks/bit plus a 7-bit, 2-stop-bit frame at 2 clks/bit.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] valid_v;
   logic [8:0] data_v [4];

   logic r0, r1, r2, r3;
   logic o0, o1, o2, o3;
   logic s0, s1, s2, s3;
   logic d0, d1, d2, d3;
   logic [3:0] rdy_v, dout_v, stat_v, done_v;

   assign rdy_v  = {r3, r2, r1, r0};
   assign dout_v = {o3, o2, o1, o0};
   assign stat_v = {s3, s2, s1, s0};
   assign done_v = {d3, d2, d1, d0};

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_np (
      .clk(clk), .rst(rst), .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]),
      .tx_ready(r0), .dout(o0), .tx_status(s0), .tx_done(d0));

   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
      .clk(clk), .rst(rst), .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]),
      .tx_ready(r1), .dout(o1), .tx_status(s1), .tx_done(d1));

   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .rst(rst), .tx_data(data_v[2][7:0]), .tx_valid(valid_v[2]),
      .tx_ready(r2), .dout(o2), .tx_status(s2), .tx_done(d2));

   uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_short (
      .clk(clk), .rst(rst), .tx_data(data_v[3][6:0]), .tx_valid(valid_v[3]),
      .tx_ready(r3), .dout(o3), .tx_status(s3), .tx_done(d3));

   // Present a word from idle; returns tx_ready as seen just before the accepting edge.
   task automatic start_frame(input int k, input logic [8:0] d, output logic rdy);
      @(negedge clk);
      rdy        = rdy_v[k];
      valid_v[k] = 1'b1;
      data_v[k]  = d;
      @(posedge clk);
      #1;
      valid_v[k] = 1'b0;
   endtask

   // Watch one frame cycle by cycle (cycle 1 = first cycle after the accepting edge).
   task automatic capture(input int k, input int cpb, input int nbits, input logic [15:0] bits,
                          output int bad_dout, output int bad_stat, output int bad_rdy,
                          output int done_cnt, output int done_pos);
      int len;
      len      = nbits * cpb;
      bad_dout = 0;
      bad_stat = 0;
      bad_rdy  = 0;
      done_cnt = 0;
      done_pos = -1;
      for (int n = 1; n <= len; n++) begin
         @(negedge clk);
         if (dout_v[k] !== bits[(n - 1) / cpb]) bad_dout++;
         if (stat_v[k] !== 1'b0) bad_stat++;
         if (rdy_v[k] !== (n == len)) bad_rdy++;
         if (done_v[k] === 1'b1) begin
            done_cnt++;
            done_pos = n;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dout_v[k] !== 1'b1) $display("FAIL reset_dout[%0d]: got %b want 1", k, dout_v[k]);
         else passes++;
         checks++;
         if (stat_v[k] !== 1'b1) $display("FAIL reset_status[%0d]: got %b want 1", k, stat_v[k]);
         else passes++;
         checks++;
         if (rdy_v[k] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy_v[k]);
         else passes++;
         checks++;
         if (done_v[k] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", k, done_v[k]);
         else passes++;
      end
      rst = 1'b0;
   endtask

   task automatic test_frame(input int k, input int cpb, input int nbits, input logic [8:0] d,
                             input logic [15:0] bits, input string name);
      logic rdy;
      int bd, bs, br, dc, dp;
      start_frame(k, d, rdy);
      capture(k, cpb, nbits, bits, bd, bs, br, dc, dp);
      checks++;
      if (rdy !== 1'b1) $display("FAIL %s_ready_idle: got %b want 1", name, rdy);
      else passes++;
      checks++;
      if (bd != 0) $display("FAIL %s_dout: %0d wrong cycles want 0", name, bd);
      else passes++;
      checks++;
      if (bs != 0) $display("FAIL %s_status: %0d cycles not busy want 0", name, bs);
      else passes++;
      checks++;
      if (br != 0) $display("FAIL %s_ready: %0d wrong cycles want 0", name, br);
      else passes++;
      checks++;
      if (dc != 1 || dp != nbits * cpb)
         $display("FAIL %s_done: %0d pulses at cycle %0d want 1 at %0d", name, dc, dp, nbits * cpb);
      else passes++;
      @(negedge clk);
      checks++;
      if (stat_v[k] !== 1'b1 || dout_v[k] !== 1'b1)
         $display("FAIL %s_idle_after: status %b dout %b want 1 1", name, stat_v[k], dout_v[k]);
      else passes++;
   endtask

   task automatic test_no_parity();
      // 0xA5: start 0, data 1,0,1,0,0,1,0,1, stop 1 -> 40 clks
      test_frame(0, 4, 10, 9'h0A5, 16'({1'b1, 8'hA5, 1'b0}), "np_a5");
   endtask

   task automatic test_parity();
      // 0xA5 has four ones: even parity bit 0, odd parity bit 1 -> 44 clks
      test_frame(1, 4, 11, 9'h0A5, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), "even_a5");
      test_frame(2, 4, 11, 9'h0A5, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), "odd_a5");
      test_frame(2, 4, 11, 9'h001, 16'({1'b1, 1'b0, 8'h01, 1'b0}), "odd_01");
   endtask

   task automatic test_short_frame();
      // 7 data bits, 2 stop bits, 2 clks/bit: 0 + seven 1s + 1,1 -> 20 clks
      test_frame(3, 2, 10, 9'h07F, 16'({2'b11, 7'h7F, 1'b0}), "short_7f");
   endtask

   task automatic test_back_to_back();
      logic rdy;
      int bd1, bs1, br1, dc1, dp1;
      int bd2, bs2, br2, dc2, dp2;
      @(negedge clk);
      rdy        = rdy_v[0];
      valid_v[0] = 1'b1;
      data_v[0]  = 9'h000;
      @(posedge clk);
      #1;
      data_v[0] = 9'h0FF;
      fork
         begin
            capture(0, 4, 10, 16'({1'b1, 8'h00, 1'b0}), bd1, bs1, br1, dc1, dp1);
            capture(0, 4, 10, 16'({1'b1, 8'hFF, 1'b0}), bd2, bs2, br2, dc2, dp2);
         end
         begin
            repeat (40) @(posedge clk);
            #1;
            valid_v[0] = 1'b0;
         end
      join
      checks++;
      if (rdy !== 1'b1) $display("FAIL b2b_ready_idle: got %b want 1", rdy);
      else passes++;
      checks++;
      if (bd1 != 0 || bd2 != 0) $display("FAIL b2b_dout: %0d/%0d wrong cycles want 0/0", bd1, bd2);
      else passes++;
      checks++;
      if (bs1 != 0 || bs2 != 0) $display("FAIL b2b_status: %0d/%0d idle cycles want 0/0", bs1, bs2);
      else passes++;
      checks++;
      if (br1 != 0 || br2 != 0) $display("FAIL b2b_ready: %0d/%0d wrong cycles want 0/0", br1, br2);
      else passes++;
      checks++;
      if (dc1 != 1 || dp1 != 40 || dc2 != 1 || dp2 != 40)
         $display("FAIL b2b_done: %0d@%0d and %0d@%0d want 1@40 and 1@40", dc1, dp1, dc2, dp2);
      else passes++;
      @(negedge clk);
      checks++;
      if (stat_v[0] !== 1'b1) $display("FAIL b2b_idle_after: status %b want 1", stat_v[0]);
      else passes++;
   endtask

   task automatic test_reset_mid_frame();
      logic rdy;
      start_frame(0, 9'h0A5, rdy);
      // cycles 1-4 start, 5-8 bit0 ... 17-20 bit3 (0xA5 bit3 = 0)
      repeat (17) @(negedge clk);
      checks++;
      if (dout_v[0] !== 1'b0 || stat_v[0] !== 1'b0)
         $display("FAIL midrst_in_bit3: dout %b status %b want 0 0", dout_v[0], stat_v[0]);
      else passes++;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (dout_v[0] !== 1'b1 || stat_v[0] !== 1'b1 || rdy_v[0] !== 1'b1 || done_v[0] !== 1'b0)
         $display("FAIL midrst_abort: dout %b status %b ready %b done %b want 1 1 1 0",
                  dout_v[0], stat_v[0], rdy_v[0], done_v[0]);
      else passes++;
      rst = 1'b0;
      test_frame(0, 4, 10, 9'h05A, 16'({1'b1, 8'h5A, 1'b0}), "midrst_5a");
   endtask

   task automatic test_ignore_busy();
      logic rdy;
      int bd, bs, br, dc, dp;
      start_frame(0, 9'h0A5, rdy);
      fork
         capture(0, 4, 10, 16'({1'b1, 8'hA5, 1'b0}), bd, bs, br, dc, dp);
         begin
            repeat (10) @(negedge clk);
            valid_v[0] = 1'b1;
            data_v[0]  = 9'h03C;
            @(negedge clk);
            valid_v[0] = 1'b0;
            repeat (5) @(negedge clk);
            data_v[0] = 9'h0C3;
         end
      join
      checks++;
      if (bd != 0) $display("FAIL busy_dout: %0d wrong cycles want 0", bd);
      else passes++;
      checks++;
      if (dc != 1 || dp != 40) $display("FAIL busy_done: %0d at %0d want 1 at 40", dc, dp);
      else passes++;
      repeat (3) @(negedge clk);
      checks++;
      if (stat_v[0] !== 1'b1 || dout_v[0] !== 1'b1)
         $display("FAIL busy_no_second_frame: status %b dout %b want 1 1", stat_v[0], dout_v[0]);
      else passes++;
   endtask

   initial begin
      rst     = 1'b1;
      valid_v = '0;
      for (int i = 0; i < 4; i++) data_v[i] = '0;
      test_reset();
      test_no_parity();
      test_parity();
      test_short_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_ignore_busy();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
